// File: rtl/bus_arbiter4.sv
// Round-robin arbiter for the shared 8-bit data bus: grants one of four requesters,
// drives the source mux select, and releases on done, withdrawal or watchdog expiry.
module bus_arbiter4 #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam bit         WdogEn   = (TIMEOUT != 0);
    localparam logic [7:0] WdogLast = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic       timeout_q, timeout_d;

    // Winner of a search starting at rr_ptr and wrapping mod 4.
    logic [1:0] win_idx;
    logic       win_vld;

    always_comb begin
        win_idx = rr_ptr_q;
        win_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!win_vld && req[rr_ptr_q + 2'(i)]) begin
                win_idx = rr_ptr_q + 2'(i);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (win_vld) begin
                    grant_d  = 4'b0001 << win_idx;
                    sel_d    = win_idx;
                    rr_ptr_d = win_idx + 2'd1;
                    cnt_d    = 8'd0;
                    state_d  = StGrant;
                end
            end
            StGrant: begin
                if (done || !req[sel_q]) begin
                    grant_d = 4'b0000;
                    state_d = StIdle;
                end else if (WdogEn && cnt_q == WdogLast) begin
                    grant_d   = 4'b0000;
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                grant_d = 4'b0000;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            rr_ptr_q  <= 2'd0;
            cnt_q     <= 8'd0;
            grant_q   <= 4'b0000;
            sel_q     <= 2'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign busy    = (state_q == StGrant);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed bench for bus_arbiter4 with TIMEOUT=4; outputs sampled 1ns after each rising edge.
module tb_bus_arbiter4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    bus_arbiter4 #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                              input logic t);
        check_val({tag, ".grant"}, 8'(grant), 8'(g));
        check_val({tag, ".sel"}, 8'(sel), 8'(s));
        check_val({tag, ".busy"}, 8'(busy), 8'(|g));
        check_val({tag, ".timeout"}, 8'(timeout), 8'(t));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with all requesting
        rst  = 1'b1;
        req  = 4'b1111;
        done = 1'b0;
        #3;
        expect_out("rst", 4'b0000, 2'd0, 1'b0);
        #9 rst = 1'b0;
        tick();
        expect_out("first", 4'b0001, 2'd0, 1'b0);

        // Round robin: done held high, one idle cycle between grants
        done = 1'b1;
        tick(); expect_out("rr.gap0", 4'b0000, 2'd0, 1'b0);
        tick(); expect_out("rr.g1",   4'b0010, 2'd1, 1'b0);
        tick(); expect_out("rr.gap1", 4'b0000, 2'd1, 1'b0);
        tick(); expect_out("rr.g2",   4'b0100, 2'd2, 1'b0);
        tick(); expect_out("rr.gap2", 4'b0000, 2'd2, 1'b0);
        tick(); expect_out("rr.g3",   4'b1000, 2'd3, 1'b0);
        tick(); expect_out("rr.gap3", 4'b0000, 2'd3, 1'b0);
        tick(); expect_out("rr.g0",   4'b0001, 2'd0, 1'b0);

        // Grantee withdraws during cycle 1
        done = 1'b0;
        req  = 4'b0000;
        tick(); expect_out("wd0.rel", 4'b0000, 2'd0, 1'b0);
        tick(); expect_out("idle.hold", 4'b0000, 2'd0, 1'b0);

        // Single requester, done during the 3rd grant cycle
        req = 4'b0100;
        tick(); expect_out("single.c1", 4'b0100, 2'd2, 1'b0);
        tick(); expect_out("single.c2", 4'b0100, 2'd2, 1'b0);
        tick(); expect_out("single.c3", 4'b0100, 2'd2, 1'b0);
        done = 1'b1;
        tick(); expect_out("single.rel", 4'b0000, 2'd2, 1'b0);
        // rr_ptr is now 3, so requester 3 wins against everyone
        done = 1'b0;
        req  = 4'b1111;
        tick(); expect_out("ptr3", 4'b1000, 2'd3, 1'b0);

        // Asynchronous reset mid-grant
        #3 rst = 1'b1;
        #1 expect_out("arst", 4'b0000, 2'd0, 1'b0);
        req = 4'b1000;
        #2 rst = 1'b0;
        tick(); expect_out("arst.regrant", 4'b1000, 2'd3, 1'b0);

        // Watchdog: requester 1 alone, no done
        req = 4'b0010;
        tick(); expect_out("wdg.swap", 4'b0000, 2'd3, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick(); expect_out($sformatf("wdg.c%0d", i), 4'b0010, 2'd1, 1'b0);
        end
        tick(); expect_out("wdg.pulse", 4'b0000, 2'd1, 1'b1);
        tick(); expect_out("wdg.regrant", 4'b0010, 2'd1, 1'b0);

        // done coincides with watchdog expiry: done wins, no pulse
        tick(); expect_out("sim.c2", 4'b0010, 2'd1, 1'b0);
        tick(); expect_out("sim.c3", 4'b0010, 2'd1, 1'b0);
        tick(); expect_out("sim.c4", 4'b0010, 2'd1, 1'b0);
        done = 1'b1;
        tick(); expect_out("sim.rel", 4'b0000, 2'd1, 1'b0);
        done = 1'b0;
        tick(); expect_out("sim.regrant", 4'b0010, 2'd1, 1'b0);

        // Withdrawal in cycle 2: release without timeout
        tick(); expect_out("wd.c2", 4'b0010, 2'd1, 1'b0);
        req = 4'b0000;
        tick(); expect_out("wd.rel", 4'b0000, 2'd1, 1'b0);
        tick(); expect_out("wd.after", 4'b0000, 2'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
